// File: rtl/seq_det_event_counter.sv
// rtl/seq_det_event_counter.sv - match-event counter behind the "11" sequence detector
// Turns the level detect signal into counted events, run lengths and a sticky threshold irq.
module seq_det_event_counter #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det,
  input  logic             enable,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] event_cnt,
  output logic [RUN_W-1:0] last_run,
  output logic [RUN_W-1:0] max_run,
  output logic             in_run,
  output logic             irq,
  output logic             ovf
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] cur_run, cur_run_nxt;
  logic [RUN_W-1:0] last_run_nxt, max_run_nxt;
  logic [CNT_W-1:0] event_cnt_nxt, cnt_inc;
  logic             irq_nxt, ovf_nxt, event_hit, irq_set;

  assign cnt_inc = event_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_run   <= '0;
      last_run  <= '0;
      max_run   <= '0;
      event_cnt <= '0;
      in_run    <= 1'b0;
      irq       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_run   <= cur_run_nxt;
      last_run  <= last_run_nxt;
      max_run   <= max_run_nxt;
      event_cnt <= event_cnt_nxt;
      in_run    <= (state_nxt == ACTIVE);
      irq       <= irq_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_run_nxt   = cur_run;
    last_run_nxt  = last_run;
    max_run_nxt   = max_run;
    event_cnt_nxt = event_cnt;
    irq_nxt       = irq;
    ovf_nxt       = ovf;
    event_hit     = 1'b0;
    irq_set       = 1'b0;

    if (clr) begin
      state_nxt     = IDLE;
      cur_run_nxt   = '0;
      last_run_nxt  = '0;
      max_run_nxt   = '0;
      event_cnt_nxt = '0;
      irq_nxt       = 1'b0;
      ovf_nxt       = 1'b0;
    end else begin
      // Run tracking ignores enable so a mid-run enable rise never fakes an edge.
      case (state)
        IDLE: begin
          if (det) begin
            state_nxt   = ACTIVE;
            cur_run_nxt = RUN_W'(1);
            event_hit   = 1'b1;
          end
        end
        ACTIVE: begin
          if (det) begin
            cur_run_nxt = (cur_run == RUN_MAX) ? cur_run : cur_run + RUN_W'(1);
          end else begin
            state_nxt    = IDLE;
            last_run_nxt = cur_run;
            max_run_nxt  = (cur_run > max_run) ? cur_run : max_run;
            cur_run_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (event_hit && enable) begin
        if (event_cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
        end else begin
          event_cnt_nxt = cnt_inc;
          irq_set       = (thresh != '0) && (cnt_inc == thresh);
        end
      end

      // A set on the same edge as an ack wins.
      if (irq_set) begin
        irq_nxt = 1'b1;
      end else if (irq_ack) begin
        irq_nxt = 1'b0;
      end
    end
  end

endmodule
